// File: rtl/mips_single_cycle_core.sv
`default_nettype none
// ============================================================================
// Module   : mips_single_cycle_core
// Purpose  : Single-cycle 32-bit MIPS subset core with hard-coded program ROM,
//            32x32 register file, ALU, control decoder and word-addressed RAM.
//            Supports add/sub/and/or/slt, addi, lw, sw and beq.
// Revision : 1.0 - initial release
// ============================================================================
module mips_single_cycle_core #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  wire logic clk,
  input  wire logic rst    // asynchronous, active-low
);

  // Opcodes and function codes
  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_FN_ADD   = 6'h20;
  localparam logic [5:0] c_FN_SUB   = 6'h22;
  localparam logic [5:0] c_FN_AND   = 6'h24;
  localparam logic [5:0] c_FN_OR    = 6'h25;
  localparam logic [5:0] c_FN_SLT   = 6'h2A;

  // ALU operation select
  localparam logic [2:0] c_ALU_ADD = 3'd0;
  localparam logic [2:0] c_ALU_SUB = 3'd1;
  localparam logic [2:0] c_ALU_AND = 3'd2;
  localparam logic [2:0] c_ALU_OR  = 3'd3;
  localparam logic [2:0] c_ALU_SLT = 3'd4;

  // Architectural state (names kept short so they can be probed directly)
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] regs [0:31];
  logic [31:0] dmem [0:DMEM_WORDS-1];

  // Decode fields
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [4:0]  w_shamt;
  logic [5:0]  w_funct;
  logic [31:0] w_imm_ext;

  // Control
  logic        w_reg_we;
  logic        w_mem_we;
  logic        w_mem_to_reg;
  logic        w_alu_src_imm;
  logic        w_branch;
  logic        w_dst_rd;
  logic [2:0]  w_alu_op;

  // Datapath
  logic [31:0] w_rs_val;
  logic [31:0] w_rt_val;
  logic [31:0] w_alu_b;
  logic [31:0] w_alu_y;
  logic [31:0] w_mem_rdata;
  logic [31:0] w_wb_data;
  logic [4:0]  w_wr_addr;
  logic [5:0]  w_dmem_idx;
  logic        w_dmem_ok;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;

  // Program image; unlisted words read as zero (a no-op)
  function automatic logic [31:0] rom_word(input logic [5:0] a);
    case (a)
      6'd0:    rom_word = 32'h20020005;
      6'd1:    rom_word = 32'h2003000c;
      6'd2:    rom_word = 32'h2067fff7;
      6'd3:    rom_word = 32'h00e22025;
      6'd4:    rom_word = 32'h00642824;
      6'd5:    rom_word = 32'h00a42820;
      6'd6:    rom_word = 32'h10a70009;
      6'd7:    rom_word = 32'h0064202a;
      6'd8:    rom_word = 32'h10800001;
      6'd9:    rom_word = 32'h20050000;
      6'd10:   rom_word = 32'h00e2202a;
      6'd11:   rom_word = 32'h00853820;
      6'd12:   rom_word = 32'h00e23822;
      6'd13:   rom_word = 32'hac670044;
      6'd14:   rom_word = 32'h8c020050;
      6'd15:   rom_word = 32'h20020001;
      6'd16:   rom_word = 32'hac020054;
      default: rom_word = 32'h00000000;
    endcase
  endfunction

  // Fetch: word index from pc[7:2], zero beyond the configured ROM depth
  always_comb begin
    instr = 32'h0;
    if ({26'd0, pc[7:2]} < 32'(IMEM_WORDS)) begin
      instr = rom_word(pc[7:2]);
    end
  end

  assign w_op      = instr[31:26];
  assign w_rs      = instr[25:21];
  assign w_rt      = instr[20:16];
  assign w_rd      = instr[15:11];
  assign w_shamt   = instr[10:6];
  assign w_funct   = instr[5:0];
  assign w_imm_ext = {{16{instr[15]}}, instr[15:0]};

  // Control decoder; anything unrecognised leaves every enable low
  always_comb begin
    w_reg_we      = 1'b0;
    w_mem_we      = 1'b0;
    w_mem_to_reg  = 1'b0;
    w_alu_src_imm = 1'b0;
    w_branch      = 1'b0;
    w_dst_rd      = 1'b0;
    w_alu_op      = c_ALU_ADD;
    case (w_op)
      c_OP_RTYPE: begin
        // A nonzero shift-amount field is not a valid encoding for these
        // functs, so such words fall through as no-ops.
        if (w_shamt == 5'd0) begin
          w_dst_rd = 1'b1;
          case (w_funct)
            c_FN_ADD: begin w_reg_we = 1'b1; w_alu_op = c_ALU_ADD; end
            c_FN_SUB: begin w_reg_we = 1'b1; w_alu_op = c_ALU_SUB; end
            c_FN_AND: begin w_reg_we = 1'b1; w_alu_op = c_ALU_AND; end
            c_FN_OR:  begin w_reg_we = 1'b1; w_alu_op = c_ALU_OR;  end
            c_FN_SLT: begin w_reg_we = 1'b1; w_alu_op = c_ALU_SLT; end
            default:  w_reg_we = 1'b0;
          endcase
        end
      end
      c_OP_ADDI: begin
        w_reg_we      = 1'b1;
        w_alu_src_imm = 1'b1;
      end
      c_OP_LW: begin
        w_reg_we      = 1'b1;
        w_alu_src_imm = 1'b1;
        w_mem_to_reg  = 1'b1;
      end
      c_OP_SW: begin
        w_mem_we      = 1'b1;
        w_alu_src_imm = 1'b1;
      end
      c_OP_BEQ: begin
        w_branch = 1'b1;
        w_alu_op = c_ALU_SUB;
      end
      default: w_reg_we = 1'b0;
    endcase
  end

  // Register file read ports; $0 is forced to zero
  assign w_rs_val = (w_rs == 5'd0) ? 32'h0 : regs[w_rs];
  assign w_rt_val = (w_rt == 5'd0) ? 32'h0 : regs[w_rt];

  assign w_alu_b = w_alu_src_imm ? w_imm_ext : w_rt_val;

  // ALU: wrapping two's-complement arithmetic, signed set-less-than
  always_comb begin
    w_alu_y = 32'h0;
    case (w_alu_op)
      c_ALU_ADD: w_alu_y = w_rs_val + w_alu_b;
      c_ALU_SUB: w_alu_y = w_rs_val - w_alu_b;
      c_ALU_AND: w_alu_y = w_rs_val & w_alu_b;
      c_ALU_OR:  w_alu_y = w_rs_val | w_alu_b;
      c_ALU_SLT: w_alu_y = ($signed(w_rs_val) < $signed(w_alu_b)) ? 32'd1 : 32'd0;
      default:   w_alu_y = 32'h0;
    endcase
  end

  // Data RAM addressing: byte address bits [7:2], low two bits ignored
  assign w_dmem_idx  = w_alu_y[7:2];
  assign w_dmem_ok   = ({26'd0, w_dmem_idx} < 32'(DMEM_WORDS));
  assign w_mem_rdata = w_dmem_ok ? dmem[w_dmem_idx] : 32'h0;

  assign w_wb_data = w_mem_to_reg ? w_mem_rdata : w_alu_y;
  assign w_wr_addr = w_dst_rd ? w_rd : w_rt;

  // Next pc: branch when the subtract result is zero (rs == rt)
  assign w_pc_plus4 = pc + 32'd4;
  assign w_pc_next  = (w_branch && (w_alu_y == 32'h0))
                    ? (w_pc_plus4 + {w_imm_ext[29:0], 2'b00})
                    : w_pc_plus4;

  // Program counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= 32'h0;
    end else begin
      pc <= w_pc_next;
    end
  end

  // Register file write port; writes to $0 are dropped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= 32'h0;
      end
    end else if (w_reg_we && (w_wr_addr != 5'd0)) begin
      regs[w_wr_addr] <= w_wb_data;
    end
  end

  // Data RAM write port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        dmem[i] <= 32'h0;
      end
    end else if (w_mem_we && w_dmem_ok) begin
      dmem[w_dmem_idx] <= w_rt_val;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_single_cycle_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_single_cycle_core
// Purpose  : Self-checking bench for mips_single_cycle_core. Expected per-cycle
//            architectural state is queued as each clock is issued and popped
//            for comparison once the edge has retired the instruction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_single_cycle_core;

  typedef struct {
    logic [31:0] pc;    // pc after the edge
    int          kind;  // 0 = register, 1 = data RAM word
    int          idx;
    logic [31:0] val;
  } vec_t;

  logic clk;
  logic rst;

  int total;
  int bad;

  vec_t tbl [16];
  vec_t sb  [$];

  mips_single_cycle_core #(
    .IMEM_WORDS(64),
    .DMEM_WORDS(64)
  ) dut (
    .clk(clk),
    .rst(rst)
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Issue n clocks, scoreboarding the first n table rows
  task automatic run_table(input int n, input string tag);
    vec_t e;
    for (int i = 0; i < n; i++) begin
      sb.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("%s_c%0d_pc", tag, i + 1), dut.pc, e.pc);
      if (e.kind == 0) begin
        check($sformatf("%s_c%0d_r%0d", tag, i + 1, e.idx), dut.regs[e.idx], e.val);
      end else begin
        check($sformatf("%s_c%0d_m%0d", tag, i + 1, e.idx), dut.dmem[e.idx], e.val);
      end
    end
  endtask

  // Drop reset between edges and check that state clears without a clock
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b0;
    #1;
    check({tag, "_pc"},    dut.pc,       32'h0);
    check({tag, "_r2"},    dut.regs[2],  32'h0);
    check({tag, "_r5"},    dut.regs[5],  32'h0);
    check({tag, "_r7"},    dut.regs[7],  32'h0);
    check({tag, "_m20"},   dut.dmem[20], 32'h0);
    check({tag, "_m21"},   dut.dmem[21], 32'h0);
    check({tag, "_instr"}, dut.instr,    32'h20020005);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    clk   = 1'b0;
    rst   = 1'b0;
    total = 0;
    bad   = 0;

    // Expected state after each of the 16 retired instructions
    tbl[0]  = '{32'h04, 0,  2, 32'd5};
    tbl[1]  = '{32'h08, 0,  3, 32'd12};
    tbl[2]  = '{32'h0C, 0,  7, 32'd3};
    tbl[3]  = '{32'h10, 0,  4, 32'd7};
    tbl[4]  = '{32'h14, 0,  5, 32'd4};
    tbl[5]  = '{32'h18, 0,  5, 32'd11};
    tbl[6]  = '{32'h1C, 0,  5, 32'd11};   // beq not taken
    tbl[7]  = '{32'h20, 0,  4, 32'd0};    // slt false
    tbl[8]  = '{32'h28, 0,  5, 32'd11};   // beq taken, word 9 skipped
    tbl[9]  = '{32'h2C, 0,  4, 32'd1};    // slt true
    tbl[10] = '{32'h30, 0,  7, 32'd12};
    tbl[11] = '{32'h34, 0,  7, 32'd7};
    tbl[12] = '{32'h38, 1, 20, 32'd7};    // sw to byte 80
    tbl[13] = '{32'h3C, 0,  2, 32'd7};    // lw from byte 80
    tbl[14] = '{32'h40, 0,  2, 32'd1};
    tbl[15] = '{32'h44, 1, 21, 32'd1};    // sw to byte 84

    // Reset held across an edge
    @(posedge clk);
    #1;
    check("rst_pc", dut.pc, 32'h0);
    for (int i = 0; i < 32; i++) begin
      check($sformatf("rst_r%0d", i), dut.regs[i], 32'h0);
    end
    check("rst_m20",   dut.dmem[20], 32'h0);
    check("rst_m21",   dut.dmem[21], 32'h0);
    check("rst_instr", dut.instr,    32'h20020005);
    @(negedge clk);
    rst = 1'b1;

    // Full program
    run_table(16, "run1");

    // Trailing no-ops: pc advances, nothing else changes
    repeat (10) @(posedge clk);
    #1;
    check("idle_pc",    dut.pc,       32'h6C);
    check("idle_instr", dut.instr,    32'h0);
    check("idle_r0",    dut.regs[0],  32'h0);
    check("idle_r2",    dut.regs[2],  32'd1);
    check("idle_r3",    dut.regs[3],  32'd12);
    check("idle_r4",    dut.regs[4],  32'd1);
    check("idle_r5",    dut.regs[5],  32'd11);
    check("idle_r7",    dut.regs[7],  32'd7);
    check("idle_m20",   dut.dmem[20], 32'd7);
    check("idle_m21",   dut.dmem[21], 32'd1);

    // Async reset after RAM has been written, then a partial rerun
    async_reset("arst1");
    run_table(9, "run2");

    // Async reset mid-program, then the full program again
    async_reset("arst2");
    run_table(16, "run3");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_single_cycle_core.md
Name: mips_single_cycle_core

Overview:
- Self-contained single-cycle 32-bit MIPS subset processor: PC, hard-coded instruction ROM, 32x32 register file, ALU, control decoder, word-addressed data RAM.
- Executes one instruction per clock.
- Top-level only: no ports besides clock and reset; state is checked through internal signals.

Parameters:
- IMEM_WORDS, 64, instruction ROM depth in 32-bit words.
- DMEM_WORDS, 64, data RAM depth in 32-bit words.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.

Behaviour:
- Reset (rst=0, async): pc=0, all 32 registers=0, all data RAM words=0; held while low. First instruction executes on the first rising edge after rst goes high.
- Fetch: instr = imem[pc[7:2]]; pc increments by 4 each cycle unless a branch is taken. ROM words beyond the program read 0.
- Supported opcodes:
  - R-type (op 0): funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - addi 0x08, lw 0x23, sw 0x2B, beq 0x04.
  - All other opcodes/functs (including 0x00000000) are no-ops: pc+4, no writes.
- Arithmetic: 32-bit two's complement; add/sub wrap, no overflow trap.
  - slt is signed; result 1 or 0.
  - Immediate is sign-extended to 32 bits.
- Writeback:
  - R-type writes rd; addi/lw write rt.
  - Write occurs at the rising edge ending the instruction.
  - Writes to $0 are discarded; $0 always reads 0.
- Register file: two combinational read ports, one write port.
- lw/sw effective address = rs + signext(imm); RAM index = address[7:2]; low 2 bits ignored.
  - sw writes rt at the clock edge.
  - lw reads combinationally, writes to rt at the edge.
- beq: if rs==rt, next pc = pc+4 + (signext(imm)<<2); otherwise pc+4.
- Internal observable signals: pc, regs[0..31], dmem[0..DMEM_WORDS-1], instr.
- ROM contents, hex, word 0 up:
  - 20020005, 2003000c, 2067fff7, 00e22025, 00642824, 00a42820
  - 10a70009, 0064202a, 10800001, 20050000, 00e2202a, 00853820
  - 00e23822, ac670044, 8c020050, 20020001, ac020054
  - Remaining words 0.
- Program effect:
  - $2=5, $3=12, $7=3, $4=7, $5=4, $5=11.
  - beq not taken. slt $4=0. beq taken, so word 9 is skipped.
  - slt $4=1, $7=12, $7=7, mem[80]=7, $2=7, $2=1, mem[84]=1.
  - 16 instructions execute; then no-ops.
- Reset asserted mid-program: immediate return to pc=0 with registers and RAM cleared; program reruns after release.

Test Plan:
- Hold rst=0 for 1 cycle -> pc=0, all regs 0, dmem[20]=0, dmem[21]=0.
- Release reset, run 6 cycles -> $2=5, $3=12, $7=3, $4=7, $5=11; pc=0x18.
- Cycles 7-9 -> beq at 0x18 not taken (pc becomes 0x1C); $4=0; beq at 0x20 taken (pc becomes 0x28); $5 remains 11.
- Cycles 10-14 -> $4=1, $7=7, dmem[20] (byte addr 80)=7, $2=7.
- Cycles 15-16 -> $2=1, dmem[21] (byte addr 84)=1; later cycles change no state, pc keeps incrementing by 4.
- Assert rst low mid-run (async, between edges) -> pc, regs, and RAM clear immediately; after release, the same sequence repeats.
